// File: rtl/alu_issue_if.sv
// Bundles the instruction stream, the ALU operand/result wires and the result stream.
// The stage uses the slave side and its driver/ALU/consumer use the master side.
interface alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [5:0]  alu_opcode;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [4:0]  alu_shift;
    logic [15:0] alu_y;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic [2:0]  res_rd;

    modport slave (
        input  in_valid, in_instr, alu_y, res_ready,
        output in_ready, alu_opcode, alu_a, alu_b, alu_shift,
        output res_valid, res_data, res_rd
    );

    modport master (
        output in_valid, in_instr, alu_y, res_ready,
        input  in_ready, alu_opcode, alu_a, alu_b, alu_shift,
        input  res_valid, res_data, res_rd
    );
endinterface

// File: rtl/alu_issue.sv
// Issue/writeback stage around an external combinational ALU with an 8x16 register file.
//   state | meaning
//   IDLE  | no instruction in flight, no result pending
//   ISSUE | operands on the ALU; result captured at the end of this cycle
//   WB    | result presented, waiting for the consumer
module alu_issue #(
    parameter int          NREGS  = 8,
    parameter logic [5:0]  LDI_OP = 6'h3F
) (
    input  logic      clk,
    input  logic      rst,
    alu_issue_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WB} state_t;

    state_t      state;
    state_t      state_nxt;
    logic        in_ready;
    logic        accept;
    logic [15:0] result;

    logic [5:0]  op_q;
    logic [2:0]  rd_q;
    logic [15:0] imm_q;
    logic [5:0]  alu_opcode_q;
    logic [15:0] alu_a_q;
    logic [15:0] alu_b_q;
    logic [4:0]  alu_shift_q;
    logic        res_valid_q;
    logic [15:0] res_data_q;
    logic [2:0]  res_rd_q;
    logic [15:0] rf [NREGS];

    logic [5:0]  in_op;
    logic [2:0]  in_rd;
    logic [2:0]  in_rs;
    logic [2:0]  in_rt;
    logic [4:0]  in_shift;
    logic [15:0] in_imm;

    assign in_op    = bus.in_instr[31:26];
    assign in_rd    = bus.in_instr[25:23];
    assign in_rs    = bus.in_instr[22:20];
    assign in_rt    = bus.in_instr[19:17];
    assign in_shift = bus.in_instr[16:12];
    assign in_imm   = bus.in_instr[15:0];

    always_comb begin
        state_nxt = state;
        in_ready  = (state == IDLE) || ((state == WB) && bus.res_ready);
        accept    = bus.in_valid && in_ready;
        result    = (op_q == LDI_OP) ? imm_q : bus.alu_y;
        case (state)
            IDLE:    if (accept) state_nxt = ISSUE;
            ISSUE:   state_nxt = WB;
            WB:      if (bus.res_ready) state_nxt = accept ? ISSUE : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            op_q         <= '0;
            rd_q         <= '0;
            imm_q        <= '0;
            alu_opcode_q <= '0;
            alu_a_q      <= '0;
            alu_b_q      <= '0;
            alu_shift_q  <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_rd_q     <= '0;
            for (int i = 0; i < NREGS; i++) rf[i] <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q  <= in_op;
                rd_q  <= in_rd;
                imm_q <= in_imm;
                // LDI never reaches the ALU, so its operand registers keep the last ALU op
                if (in_op != LDI_OP) begin
                    alu_opcode_q <= in_op;
                    alu_a_q      <= rf[in_rs];
                    alu_b_q      <= rf[in_rt];
                    alu_shift_q  <= in_shift;
                end
            end
            if (state == ISSUE) begin
                if (rd_q != 3'd0) rf[rd_q] <= result;
                res_data_q  <= result;
                res_rd_q    <= rd_q;
                res_valid_q <= 1'b1;
            end else if ((state == WB) && bus.res_ready && !accept) begin
                res_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.alu_opcode = alu_opcode_q;
    assign bus.alu_a      = alu_a_q;
    assign bus.alu_b      = alu_b_q;
    assign bus.alu_shift  = alu_shift_q;
    assign bus.res_valid  = res_valid_q;
    assign bus.res_data   = res_data_q;
    assign bus.res_rd     = res_rd_q;
endmodule

// File: tb/tb_alu_issue.sv
// Randomised self-checking bench for alu_issue; the ALU and the register file are modelled here.
module tb_alu_issue;
    localparam logic [5:0] LDI = 6'h3F;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_issue_if bus();
    alu_issue dut (.clk(clk), .rst(rst), .bus(bus));

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int res_cyc;
    int prev_res_cyc;

    logic [15:0] m_rf [8];
    logic [5:0]  m_aop;
    logic [15:0] m_a, m_b;
    logic [4:0]  m_sh;
    logic [15:0] pend_res;
    logic [2:0]  pend_rd;
    logic [15:0] got;

    function automatic logic [15:0] alu_ref(logic [5:0] op, logic [15:0] a, logic [15:0] b,
                                            logic [4:0] sh);
        logic [31:0] wide;
        case (op)
            6'd1:    wide = (32'(a) << sh) + 32'(b);
            6'd2:    wide = 32'(a) - 32'(b);
            6'd3:    wide = 32'(a & b);
            6'd4:    wide = 32'(a | b);
            default: wide = 32'(a ^ b ^ {10'd0, op});
        endcase
        return wide[15:0];
    endfunction

    assign bus.alu_y = alu_ref(bus.alu_opcode, bus.alu_a, bus.alu_b, bus.alu_shift);

    always @(posedge clk) begin
        cyc++;
        if (cyc > 50000) begin
            $display("FAIL watchdog: got %0d cycles want < 50000", cyc);
            $fatal(1);
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ldi(logic [2:0] rd, logic [15:0] imm);
        return {LDI, rd, 7'd0, imm};
    endfunction

    function automatic logic [31:0] rop(logic [5:0] op, logic [2:0] rd, logic [2:0] rs,
                                        logic [2:0] rt, logic [4:0] sh);
        return {op, rd, rs, rt, sh, 12'd0};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        m_aop = '0; m_a = '0; m_b = '0; m_sh = '0;
    endtask

    // Called at a negedge with the stage in IDLE or WB; returns at the negedge of ISSUE.
    task automatic start_instr(input logic [31:0] instr);
        logic [5:0] op;
        op = instr[31:26];
        bus.res_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_instr  = instr;
        #1;
        check_val("in_ready_accept", 32'(bus.in_ready), 32'd1);
        if (op != LDI) begin
            m_aop = op;
            m_a   = m_rf[instr[22:20]];
            m_b   = m_rf[instr[19:17]];
            m_sh  = instr[16:12];
            pend_res = alu_ref(m_aop, m_a, m_b, m_sh);
        end else begin
            pend_res = instr[15:0];
        end
        pend_rd = instr[25:23];
        @(negedge clk);
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b0;
        check_val("in_ready_issue", 32'(bus.in_ready), 32'd0);
        check_val("alu_opcode", 32'(bus.alu_opcode), 32'(m_aop));
        check_val("alu_a", 32'(bus.alu_a), 32'(m_a));
        check_val("alu_b", 32'(bus.alu_b), 32'(m_b));
        check_val("alu_shift", 32'(bus.alu_shift), 32'(m_sh));
    endtask

    // From the ISSUE negedge: checks the presented result, then backpressures for `stall` cycles.
    task automatic finish_instr(input int stall, output logic [15:0] res);
        @(negedge clk);
        prev_res_cyc = res_cyc;
        res_cyc = cyc;
        check_val("res_valid", 32'(bus.res_valid), 32'd1);
        check_val("res_data", 32'(bus.res_data), 32'(pend_res));
        check_val("res_rd", 32'(bus.res_rd), 32'(pend_rd));
        check_val("in_ready_wb", 32'(bus.in_ready), 32'd0);
        if (pend_rd != 3'd0) m_rf[pend_rd] = pend_res;
        res = bus.res_data;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            check_val("hold_valid", 32'(bus.res_valid), 32'd1);
            check_val("hold_data", 32'(bus.res_data), 32'(pend_res));
            check_val("hold_rd", 32'(bus.res_rd), 32'(pend_rd));
            check_val("hold_in_ready", 32'(bus.in_ready), 32'd0);
        end
    endtask

    task automatic do_instr(input logic [31:0] instr, input int stall, output logic [15:0] res);
        start_instr(instr);
        finish_instr(stall, res);
    endtask

    task automatic drain();
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        check_val("drain_valid", 32'(bus.res_valid), 32'd0);
        check_val("drain_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic apply_reset();
        bus.in_valid  = 1'b0;
        bus.res_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_val("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check_val("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check_val("rst_res_data", 32'(bus.res_data), 32'd0);
        check_val("rst_res_rd", 32'(bus.res_rd), 32'd0);
        check_val("rst_alu_opcode", 32'(bus.alu_opcode), 32'd0);
        check_val("rst_alu_a", 32'(bus.alu_a), 32'd0);
        check_val("rst_alu_b", 32'(bus.alu_b), 32'd0);
        check_val("rst_alu_shift", 32'(bus.alu_shift), 32'd0);
    endtask

    initial begin
        logic [31:0] instr;
        logic [5:0]  op;
        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_instr  = '0;
        bus.res_ready = 1'b0;
        res_cyc = 0;
        prev_res_cyc = 0;
        model_reset();
        repeat (2) @(negedge clk);
        apply_reset();

        // Directed: LDI r1=3, LDI r2=5, ADD r3 = (r1<<2)+r2 = 17
        do_instr(ldi(3'd1, 16'd3), 0, got);
        check_val("ldi_r1", 32'(got), 32'd3);
        do_instr(ldi(3'd2, 16'd5), 0, got);
        check_val("ldi_r2", 32'(got), 32'd5);
        start_instr(rop(6'd1, 3'd3, 3'd1, 3'd2, 5'd2));
        check_val("add_alu_a", 32'(bus.alu_a), 32'd3);
        check_val("add_alu_b", 32'(bus.alu_b), 32'd5);
        check_val("add_alu_shift", 32'(bus.alu_shift), 32'd2);
        finish_instr(0, got);
        check_val("add_res", 32'(got), 32'd17);

        // Back-to-back dependent chain, one result every 2 cycles, wrapping to 0
        do_instr(ldi(3'd1, 16'd1), 0, got);
        for (int i = 0; i < 16; i++) begin
            do_instr(rop(6'd1, 3'd1, 3'd1, 3'd0, 5'd1), 0, got);
            check_val("chain_res", 32'(got), (32'd1 << (i + 1)) & 32'hFFFF);
            check_val("chain_rate", 32'(res_cyc - prev_res_cyc), 32'd2);
        end

        // Backpressure for 5 cycles, then next instruction accepted on the handshake cycle
        do_instr(ldi(3'd5, 16'hA5A5), 5, got);
        do_instr(rop(6'd2, 3'd6, 3'd5, 3'd2, 5'd0), 0, got);
        check_val("bp_next", 32'(got), 32'(16'hA5A5 - 16'd5));
        drain();

        // r0 is hardwired to zero but its result is still emitted
        do_instr(ldi(3'd0, 16'hBEEF), 0, got);
        check_val("r0_ldi_data", 32'(got), 32'hBEEF);
        check_val("r0_ldi_rd", 32'(bus.res_rd), 32'd0);
        do_instr(rop(6'd1, 3'd4, 3'd0, 3'd0, 5'd0), 0, got);
        check_val("r0_read", 32'(got), 32'd0);
        drain();

        // Reset in ISSUE, then in WB under backpressure; RF must read back as zero
        do_instr(ldi(3'd1, 16'd7), 0, got);
        start_instr(rop(6'd1, 3'd3, 3'd1, 3'd2, 5'd0));
        apply_reset();
        do_instr(ldi(3'd2, 16'd9), 0, got);
        do_instr(rop(6'd1, 3'd1, 3'd2, 3'd2, 5'd0), 0, got);
        start_instr(rop(6'd3, 3'd4, 3'd1, 3'd2, 5'd0));
        @(negedge clk);
        apply_reset();
        do_instr(rop(6'd1, 3'd3, 3'd1, 3'd2, 5'd0), 0, got);
        check_val("post_rst_add", 32'(got), 32'd0);
        drain();

        // Randomised mix of LDI and ALU ops with random backpressure
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 3))
                0:       op = LDI;
                1:       op = 6'($urandom_range(1, 4));
                2:       op = 6'($urandom_range(0, 62));
                default: op = 6'd1;
            endcase
            instr = $urandom;
            instr[31:26] = op;
            do_instr(instr, int'($urandom_range(0, 3)), got);
            if ($urandom_range(0, 7) == 0) drain();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
